// File: rtl/cache_ring_stop.sv
// Ring stop: buffers upstream packets, delivers last-hop packets locally and
// merges local injections into a registered, stall-safe output stream.
module cache_ring_stop #(
   parameter int PAYLOAD_W  = 160,
   parameter int TTL_W      = 2,
   parameter int TTL_MAX    = 3,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [TTL_W-1:0]             in_ttl,
   input  logic [PAYLOAD_W-1:0]         in_payload,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [TTL_W-1:0]             out_ttl,
   output logic [PAYLOAD_W-1:0]         out_payload,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   input  logic [PAYLOAD_W-1:0]         tx_payload,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic [TTL_W-1:0]             rx_ttl,
   output logic [PAYLOAD_W-1:0]         rx_payload,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LVL_W = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [TTL_W-1:0]     ttl_mem_q [DEPTH];
   logic [PAYLOAD_W-1:0] pay_mem_q [DEPTH];

   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 out_valid_q, out_valid_d;
   logic [TTL_W-1:0]     out_ttl_q, out_ttl_d;
   logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
   logic [CNT_W-1:0]     starve_q, starve_d;

   logic                 head_valid;
   logic                 last_hop;
   logic                 fwd_cand;
   logic                 loadable;
   logic                 tx_win;
   logic                 fwd_win;
   logic                 push;
   logic                 pop;
   logic [TTL_W-1:0]     head_ttl;
   logic [PAYLOAD_W-1:0] head_payload;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_ttl     = ttl_mem_q[rd_ptr_q];
   assign head_payload = pay_mem_q[rd_ptr_q];
   assign in_ready     = (level_q != LVL_W'(DEPTH));

   always_comb begin
      head_valid = (level_q != '0);
      last_hop   = head_valid && (head_ttl == '0);
      fwd_cand   = head_valid && (head_ttl != '0);
      loadable   = !out_valid_q || out_ready;
      // A starved injection overrides the forward candidate for one slot.
      tx_win     = loadable && tx_valid && (!fwd_cand || (starve_q == CNT_W'(STARVE_MAX)));
      fwd_win    = loadable && fwd_cand && !tx_win;
      push       = in_valid && in_ready;
      pop        = (last_hop && rx_ready) || fwd_win;
   end

   always_comb begin
      wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d       = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      out_valid_d   = loadable ? (tx_win || fwd_win) : out_valid_q;
      out_ttl_d     = out_ttl_q;
      out_payload_d = out_payload_q;
      if (tx_win) begin
         out_ttl_d     = TTL_W'(TTL_MAX);
         out_payload_d = tx_payload;
      end else if (fwd_win) begin
         out_ttl_d     = head_ttl - TTL_W'(1);
         out_payload_d = head_payload;
      end

      starve_d = starve_q;
      if (!tx_valid || tx_win) begin
         starve_d = '0;
      end else if (fwd_win && (starve_q != CNT_W'(STARVE_MAX))) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_valid_q <= 1'b0;
         starve_q    <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_valid_q <= out_valid_d;
         starve_q    <= starve_d;
      end
   end

   // NOTE: packet storage is deliberately left without reset; the valid and
   // level flags above already mask any stale contents.
   always_ff @(posedge clk) begin
      out_ttl_q     <= out_ttl_d;
      out_payload_q <= out_payload_d;
      if (push) begin
         ttl_mem_q[wr_ptr_q] <= in_ttl;
         pay_mem_q[wr_ptr_q] <= in_payload;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_ttl     = out_ttl_q;
   assign out_payload = out_payload_q;
   assign tx_ready    = tx_win;
   assign rx_valid    = last_hop;
   assign rx_ttl      = head_ttl;
   assign rx_payload  = head_payload;
   assign fifo_level  = level_q;

endmodule

// File: tb/tb_cache_ring_stop.sv
// Bench for cache_ring_stop: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_cache_ring_stop;

   localparam int PAYLOAD_W  = 160;
   localparam int TTL_W      = 2;
   localparam int TTL_MAX    = 3;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;
   localparam int LW         = $clog2(DEPTH + 1);

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 in_valid;
   logic                 in_ready;
   logic [TTL_W-1:0]     in_ttl;
   logic [PAYLOAD_W-1:0] in_payload;
   logic                 out_valid;
   logic                 out_ready;
   logic [TTL_W-1:0]     out_ttl;
   logic [PAYLOAD_W-1:0] out_payload;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [PAYLOAD_W-1:0] tx_payload;
   logic                 rx_valid;
   logic                 rx_ready;
   logic [TTL_W-1:0]     rx_ttl;
   logic [PAYLOAD_W-1:0] rx_payload;
   logic [LW-1:0]        fifo_level;

   always #5 clk = ~clk;

   cache_ring_stop #(
      .PAYLOAD_W (PAYLOAD_W),
      .TTL_W     (TTL_W),
      .TTL_MAX   (TTL_MAX),
      .DEPTH     (DEPTH),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ttl     (in_ttl),
      .in_payload (in_payload),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ttl    (out_ttl),
      .out_payload(out_payload),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_payload (tx_payload),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_ttl     (rx_ttl),
      .rx_payload (rx_payload),
      .fifo_level (fifo_level)
   );

   typedef struct {
      logic [TTL_W-1:0]     ttl;
      logic [PAYLOAD_W-1:0] pay;
   } pkt_t;

   // Reference model: buffered packets, the output slot and the loss count.
   pkt_t                 mq[$];
   logic                 m_ov;
   logic [TTL_W-1:0]     m_ot;
   logic [PAYLOAD_W-1:0] m_op;
   int                   m_starve;

   int total = 0;
   int bad   = 0;

   logic                 s_tx_ready;
   logic                 s_in_ready;
   logic                 s_push;
   logic [PAYLOAD_W-1:0] dep_pay[$];
   logic [TTL_W-1:0]     dep_ttl[$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ov     = 1'b0;
      m_ot     = '0;
      m_op     = '0;
      m_starve = 0;
   endtask

   function automatic logic [PAYLOAD_W-1:0] rand_pay();
      return {$urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: check all outputs against the model, then advance it.
   task automatic step();
      bit   e_in_ready, e_rx, fwd, ld, tx_go, fwd_go, push;
      pkt_t h;
      logic                 c_rx_ready, c_tx_valid, c_in_valid;
      logic [TTL_W-1:0]     c_in_ttl;
      logic [PAYLOAD_W-1:0] c_in_pay, c_tx_pay;
      #1;
      e_in_ready = (mq.size() < DEPTH);
      e_rx       = (mq.size() > 0) && (mq[0].ttl == 0);
      fwd        = (mq.size() > 0) && (mq[0].ttl != 0);
      ld         = !m_ov || out_ready;
      tx_go      = ld && tx_valid && (!fwd || (m_starve == STARVE_MAX));
      fwd_go     = ld && fwd && !tx_go;
      push       = in_valid && e_in_ready;

      chk("in_ready", in_ready, e_in_ready);
      chk("fifo_level", fifo_level, mq.size());
      chk("out_valid", out_valid, m_ov);
      if (m_ov) begin
         chk("out_ttl", out_ttl, m_ot);
         chk("out_payload", out_payload, m_op);
      end
      chk("rx_valid", rx_valid, e_rx);
      if (e_rx) begin
         chk("rx_ttl", rx_ttl, 0);
         chk("rx_payload", rx_payload, mq[0].pay);
      end
      chk("tx_ready", tx_ready, tx_go);

      s_tx_ready = tx_ready;
      s_in_ready = in_ready;
      s_push     = push;
      if (out_valid && out_ready) begin
         dep_pay.push_back(out_payload);
         dep_ttl.push_back(out_ttl);
      end
      c_rx_ready = rx_ready;
      c_tx_valid = tx_valid;
      c_in_valid = in_valid;
      c_in_ttl   = in_ttl;
      c_in_pay   = in_payload;
      c_tx_pay   = tx_payload;

      @(posedge clk);
      if (e_rx && c_rx_ready) void'(mq.pop_front());
      if (fwd_go) begin
         h    = mq.pop_front();
         m_ot = h.ttl - TTL_W'(1);
         m_op = h.pay;
      end
      if (tx_go) begin
         m_ot = TTL_W'(TTL_MAX);
         m_op = c_tx_pay;
      end
      if (ld) m_ov = tx_go || fwd_go;
      if (c_in_valid && e_in_ready) mq.push_back('{ttl: c_in_ttl, pay: c_in_pay});
      if (!c_tx_valid || tx_go) m_starve = 0;
      else if (ld && fwd && m_starve < STARVE_MAX) m_starve++;
      @(negedge clk);
   endtask

   initial begin
      int sent;
      int losses;
      bit found;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_ttl     = '0;
      in_payload = '0;
      out_ready  = 1'b0;
      tx_valid   = 1'b0;
      tx_payload = '0;
      rx_ready   = 1'b0;
      model_reset();

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_fifo_level", fifo_level, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // Single forwarded packet: two-cycle latency, TTL decremented
      in_valid = 1'b1; in_ttl = 2'd2; in_payload = 160'hA5; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("lat_out_valid", out_valid, 1);
      chk("lat_out_ttl", out_ttl, 1);
      chk("lat_out_payload", out_payload, 160'hA5);
      chk("lat_fifo_level", fifo_level, 0);
      step();

      // Last-hop packet blocks a forward candidate until consumed
      in_valid = 1'b1; in_ttl = 2'd0; in_payload = 160'h111; rx_ready = 1'b0;
      step();
      in_valid = 1'b0;
      step();
      step();
      in_valid = 1'b1; in_ttl = 2'd3; in_payload = 160'h222;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("hop_rx_valid", rx_valid, 1);
      chk("hop_rx_payload", rx_payload, 160'h111);
      chk("hop_out_blocked", out_valid, 0);
      chk("hop_level", fifo_level, 2);
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
      step();
      chk("hop_fwd_valid", out_valid, 1);
      chk("hop_fwd_ttl", out_ttl, 2);
      chk("hop_fwd_payload", out_payload, 160'h222);
      step();

      // Back-pressure: six packets against a stalled output
      out_ready = 1'b0;
      sent = 0;
      for (int i = 0; i < 12; i++) begin
         in_valid = (sent < 6); in_ttl = 2'd1; in_payload = 160'h300 + PAYLOAD_W'(sent);
         step();
         if (s_push) sent++;
      end
      chk("bp_accepted", sent, 5);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_level", fifo_level, DEPTH);
      chk("bp_out_payload", out_payload, 160'h300);
      dep_pay.delete();
      dep_ttl.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_valid = (sent < 6); in_ttl = 2'd1; in_payload = 160'h300 + PAYLOAD_W'(sent);
         step();
         if (s_push) sent++;
      end
      in_valid = 1'b0;
      chk("bp_departed", dep_pay.size(), 6);
      for (int i = 0; i < dep_pay.size(); i++) begin
         chk("bp_order", dep_pay[i], 160'h300 + PAYLOAD_W'(i));
         chk("bp_ttl", dep_ttl[i], 0);
      end

      // Starvation: injection forced through after STARVE_MAX losses
      in_valid = 1'b1; in_ttl = 2'd1; in_payload = 160'h400;
      step();
      step();
      tx_valid = 1'b1; tx_payload = 160'hBEEF;
      losses = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         in_payload = 160'h410 + PAYLOAD_W'(i);
         step();
         if (s_tx_ready) found = 1'b1;
         else losses++;
      end
      chk("starve_found", found, 1);
      chk("starve_losses", losses, STARVE_MAX);
      chk("starve_out_ttl", out_ttl, TTL_MAX);
      chk("starve_out_payload", out_payload, 160'hBEEF);
      tx_valid = 1'b0;
      step();
      chk("starve_resume_valid", out_valid, 1);
      chk("starve_resume_ttl", out_ttl, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Steady push+pop at level DEPTH-1
      out_ready = 1'b0; in_valid = 1'b1; in_ttl = 2'd1;
      for (int i = 0; i < 10 && fifo_level != LW'(DEPTH - 1); i++) begin
         in_payload = rand_pay();
         step();
      end
      chk("steady_fill", fifo_level, DEPTH - 1);
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_payload = rand_pay();
         step();
         chk("steady_level", fifo_level, DEPTH - 1);
         chk("steady_in_ready", s_in_ready, 1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) step();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid   = $urandom_range(0, 1) == 1;
         in_ttl     = TTL_W'($urandom_range(0, 3));
         in_payload = rand_pay();
         out_ready  = $urandom_range(0, 9) < 7;
         rx_ready   = $urandom_range(0, 2) != 0;
         tx_valid   = $urandom_range(0, 9) < 4;
         tx_payload = rand_pay();
         step();
      end

      // Asynchronous reset in the middle of a stall
      in_valid = 1'b1; in_ttl = 2'd1; out_ready = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
      for (int i = 0; i < 12 && fifo_level != LW'(3); i++) begin
         in_payload = rand_pay();
         step();
      end
      in_valid = 1'b0;
      chk("arst_pre_level", fifo_level, 3);
      chk("arst_pre_out_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_rx_valid", rx_valid, 0);
      chk("arst_fifo_level", fifo_level, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cache_ring_stop.md
Name: cache_ring_stop

Overview:
- Parametrised ring stop for the cache coherence ring.
- Buffers incoming ring requests in a DEPTH-entry FIFO and decrements TTL on forwarded packets.
- Delivers last-hop packets (ttl==0) to the local controller.
- Merges local injections into the outgoing stream, with anti-starvation arbitration and a registered, stall-safe output stage.
- Replaces the single-entry hold/stall pair used by earlier controllers and lets ring length, payload width and buffering scale per build.

Parameters:
PAYLOAD_W, 160, width of request payload (tag, index, flags, line data), opaque to this block
TTL_W, 2, width of TTL field; ring supports up to 2**TTL_W hops
TTL_MAX, 3, TTL loaded into locally injected packets; must be < 2**TTL_W
DEPTH, 4, input FIFO entries; >=2, need not be a power of two
STARVE_MAX, 8, consecutive cycles a pending local injection may lose arbitration before it is forced through; >=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream packet valid
in_ready  out  1  upstream accept
in_ttl  in  TTL_W  upstream packet TTL
in_payload  in  PAYLOAD_W  upstream payload
out_valid  out  1  downstream packet valid
out_ready  in  1  downstream accept
out_ttl  out  TTL_W  downstream TTL
out_payload  out  PAYLOAD_W  downstream payload
tx_valid  in  1  local injection request
tx_ready  out  1  local injection accepted this cycle
tx_payload  in  PAYLOAD_W  local injection payload
rx_valid  out  1  last-hop packet available to local controller
rx_ready  in  1  local controller consumes rx packet
rx_ttl  out  TTL_W  TTL of rx packet (always 0)
rx_payload  out  PAYLOAD_W  rx payload
fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
Interface:
- One clock.
- Reset is asynchronous and active-low: clk, rst_n.

Reset:
- FIFO empty, pointers 0, fifo_level=0.
- out_valid=0, rx_valid=0, starvation counter=0.
- in_ready=1 once reset deasserts.
- Reset mid-operation discards all buffered packets, including a stalled output packet.
- The payload/ttl storage has no reset.

Input:
- in_ready = (fifo_level != DEPTH); no combinational dependence on out_ready or rx_ready.
- Push on in_valid && in_ready.
- Push and pop may occur in the same cycle; level is unchanged.
- Pointers wrap from DEPTH-1 to 0.

Head classification (FIFO head, when non-empty):
- ttl==0 is last hop. rx_valid=1, rx_payload/rx_ttl = head.
- Pop on rx_ready. The packet is never forwarded.
- Forwarding of later entries blocks behind it (in-order).
- ttl!=0 is forward candidate, with ttl reduced to ttl-1 (no wrap, since ttl>=1).

Output stage (single register):
- Loadable when !out_valid || out_ready.
- out_valid/out_ttl/out_payload hold stable while out_valid && !out_ready.
- Latency: FIFO push to out_valid is 2 cycles minimum (push cycle, then head-to-register); local tx to out_valid is 1 cycle.

Arbitration when the output is loadable:
- Forward candidate and no tx_valid: load forward candidate, pop.
- tx_valid and no forward candidate: load {TTL_MAX, tx_payload}, tx_ready=1.
- Both present: forward wins and the starvation counter increments (saturating at STARVE_MAX).
- If the counter == STARVE_MAX at arbitration, tx wins instead and the counter clears.
- Counter clears whenever tx_ready=1 or tx_valid=0.
- tx_ready=0 whenever the output is not loadable.

fifo_level:
- Registered: +1 on push, -1 on pop (rx or forward), net 0 on both.

Test Plan:
- Reset, then push 1 packet ttl=2, payload=0xA5, out_ready=1 -> out_valid 2 cycles later with out_ttl=1, payload 0xA5; fifo_level returns 0.
- Push ttl=0 packet, rx_ready=0 for 5 cycles, then push ttl=3 behind it -> rx_valid held with payload stable; no out_valid until rx_ready pulses; then forwarded with out_ttl=2.
- out_ready=0, stream DEPTH+2=6 packets ttl=1 -> in_ready drops after 4 buffered plus 1 in output register; out_payload stable; on release, all packets leave in order with ttl=0 and none are lost.
- Continuous upstream ttl=1 traffic, out_ready=1, tx_valid=1 from cycle 0 -> tx_ready asserts after exactly STARVE_MAX=8 lost arbitrations; out_ttl=3 on that slot; forwarding resumes next cycle.
- Simultaneous push and forward pop at fifo_level=DEPTH-1 for 20 cycles -> fifo_level constant at 3, in_ready never drops.
- Assert rst_n=0 asynchronously mid-stall with 3 buffered -> out_valid, rx_valid and fifo_level go to 0 immediately, without waiting for a clock edge; no stale packet appears after release.
